// File: rtl/main_nios2_jtag_pkg.sv
// Shared types and constants for the Nios II debug-module JTAG scan master.
// The TAP step function covers only the states a 2-bit-IR / DR scan walks through.
package main_nios2_jtag_pkg;

  localparam int IR_WIDTH_DEF      = 2;
  localparam int DR_WIDTH_DEF      = 38;
  localparam int RESET_TLR_PERIODS = 5;
  localparam int RESET_SEQ_PERIODS = RESET_TLR_PERIODS + 1;

  typedef enum logic [2:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_SEL_IR,
    TAP_CAPTURE,
    TAP_SHIFT,
    TAP_EXIT1,
    TAP_UPDATE
  } tap_state_t;

  typedef enum logic [1:0] {
    CTRL_RESET,
    CTRL_IDLE,
    CTRL_SCAN
  } ctrl_state_t;

  // EXIT1 with tms=0 would really enter PAUSE; the scan never does that.
  function automatic tap_state_t tap_step(input tap_state_t s, input logic m);
    case (s)
      TAP_TLR:     return m ? TAP_TLR    : TAP_RTI;
      TAP_RTI:     return m ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:  return m ? TAP_SEL_IR : TAP_CAPTURE;
      TAP_SEL_IR:  return m ? TAP_TLR    : TAP_CAPTURE;
      TAP_CAPTURE: return m ? TAP_EXIT1  : TAP_SHIFT;
      TAP_SHIFT:   return m ? TAP_EXIT1  : TAP_SHIFT;
      TAP_EXIT1:   return m ? TAP_UPDATE : TAP_SHIFT;
      default:     return m ? TAP_SEL_DR : TAP_RTI;
    endcase
  endfunction

endpackage

// File: rtl/main_nios2_jtag_tck_gen.sv
// TCK divider: CLK_DIV clk cycles per half period, parked low while disabled.
// tck_rise/tck_fall flag the cycle whose closing clk edge moves TCK.
module main_nios2_jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $fatal(1, "main_nios2_jtag_tck_gen: CLK_DIV must be at least 1");
  end

  logic [CW-1:0] div_cnt_reg;
  logic          tck_reg;
  logic          wrap;

  assign wrap     = en && (div_cnt_reg == DIV_LAST);
  assign tck_rise = wrap && !tck_reg;
  assign tck_fall = wrap && tck_reg;
  assign tck      = tck_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      tck_reg     <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      tck_reg     <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      tck_reg     <= ~tck_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/main_nios2_jtag_scan_master.sv
// Host-side JTAG scan initiator: walks the TAP for single IR-write / DR-scan
// commands and returns the TDO bits captured during the shift periods.
module main_nios2_jtag_scan_master
  import main_nios2_jtag_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int DR_WIDTH = DR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_is_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);
  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam logic [BW-1:0] IR_LAST  = BW'(IR_WIDTH - 1);
  localparam logic [BW-1:0] DR_LAST  = BW'(DR_WIDTH - 1);
  localparam logic [2:0]    SEQ_LAST = 3'(RESET_SEQ_PERIODS - 1);
  localparam logic [2:0]    TLR_LAST = 3'(RESET_TLR_PERIODS - 1);

  ctrl_state_t         ctrl_reg, ctrl_next;
  tap_state_t          tap_reg, tap_next;
  logic [2:0]          seq_cnt_reg, seq_cnt_next;
  logic [BW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                is_ir_reg, is_ir_next;
  logic [DR_WIDTH-1:0] tx_reg, tx_next;
  logic [DR_WIDTH-1:0] rx_reg, rx_next;
  logic [DR_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic                tms_reg, tms_next;
  logic                tdi_reg, tdi_next;
  logic                tck_en, tck_rise, tck_fall;
  logic [BW-1:0]       last_idx;

  assign tck_en = (ctrl_reg != CTRL_IDLE);

  main_nios2_jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (tck_en),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  assign last_idx = is_ir_reg ? IR_LAST : DR_LAST;

  // Rising edges advance the tracked TAP and sample TDO; falling edges set
  // up TMS/TDI for the next period based on the state just entered.
  always_comb begin
    ctrl_next      = ctrl_reg;
    tap_next       = tap_reg;
    seq_cnt_next   = seq_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    is_ir_next     = is_ir_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_valid_next = 1'b0;
    tms_next       = tms_reg;
    tdi_next       = tdi_reg;
    case (ctrl_reg)
      CTRL_RESET: begin
        if (tck_rise) tap_next = tap_step(tap_reg, tms_reg);
        if (tck_fall) begin
          if (seq_cnt_reg == SEQ_LAST) begin
            ctrl_next = CTRL_IDLE;
            tms_next  = 1'b0;
          end else begin
            seq_cnt_next = seq_cnt_reg + 3'd1;
            tms_next     = (seq_cnt_reg < TLR_LAST);
          end
        end
      end
      CTRL_IDLE: begin
        if (cmd_valid) begin
          ctrl_next    = CTRL_SCAN;
          is_ir_next   = cmd_is_ir;
          tx_next      = cmd_data;
          rx_next      = '0;
          bit_cnt_next = '0;
          tms_next     = 1'b1;
          tdi_next     = 1'b0;
        end
      end
      CTRL_SCAN: begin
        if (tck_rise) begin
          tap_next = tap_step(tap_reg, tms_reg);
          if (tap_reg == TAP_SHIFT) begin
            rx_next[bit_cnt_reg] = tdo;
            bit_cnt_next         = bit_cnt_reg + 1'b1;
          end
        end
        if (tck_fall) begin
          tdi_next = 1'b0;
          case (tap_reg)
            TAP_SEL_DR: tms_next = is_ir_reg;
            TAP_SHIFT: begin
              tms_next = (bit_cnt_reg == last_idx);
              tdi_next = tx_reg[0];
              tx_next  = {1'b0, tx_reg[DR_WIDTH-1:1]};
            end
            TAP_EXIT1: tms_next = 1'b1;
            TAP_RTI: begin
              ctrl_next      = CTRL_IDLE;
              rsp_valid_next = 1'b1;
              rsp_data_next  = rx_reg;
              tms_next       = 1'b0;
            end
            default: tms_next = 1'b0;
          endcase
        end
      end
      default: ctrl_next = CTRL_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg      <= CTRL_RESET;
      tap_reg       <= TAP_TLR;
      seq_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      is_ir_reg     <= 1'b0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      tms_reg       <= 1'b1;
      tdi_reg       <= 1'b0;
    end else begin
      ctrl_reg      <= ctrl_next;
      tap_reg       <= tap_next;
      seq_cnt_reg   <= seq_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      is_ir_reg     <= is_ir_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_valid_reg <= rsp_valid_next;
      tms_reg       <= tms_next;
      tdi_reg       <= tdi_next;
    end
  end

  assign cmd_ready = (ctrl_reg == CTRL_IDLE);
  assign busy      = (ctrl_reg != CTRL_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign tms       = tms_reg;
  assign tdi       = tdi_reg;

endmodule

// File: tb/tb_main_nios2_jtag_scan_master.sv
// Bench for the JTAG scan master: a TAP-following slave model drives TDO,
// a scoreboard queue holds expected responses pushed at command accept.
module tb_main_nios2_jtag_scan_master;
  localparam int DW = 38;
  localparam int IW = 2;
  localparam logic [DW-1:0] IR_CAP = 38'h1;
  localparam int B_TLR = 0, B_RTI = 1, B_SDR = 2, B_SIR = 3;
  localparam int B_CAP = 4, B_SH = 5, B_E1 = 6, B_UP = 7;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    int            lat;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  // DUT with CLK_DIV=2
  logic cmd_valid = 1'b0, cmd_is_ir = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, busy, tck0, tms0, tdi0, tdo0;
  logic [DW-1:0] rsp_data;
  // DUT with CLK_DIV=1
  logic c1_valid = 1'b0, c1_is_ir = 1'b0;
  logic [DW-1:0] c1_data = '0;
  logic c1_ready, r1_valid, busy1, tck1, tms1, tdi1;
  logic [DW-1:0] r1_data;

  int errors = 0, checks = 0, cyc = 0;
  ev_t exp_q[$], got_q[$], exp1_q[$], got1_q[$];
  ev_t mon_e, mon1_e;

  logic loop0 = 1'b1;
  logic [DW-1:0] dr_cap = '0;
  logic [DW-1:0] slave_sr = '0;
  int b_state = B_TLR;
  logic b_ir = 1'b0;
  logic [63:0] tms_bits = '0, tdi_bits = '0;
  int tms_n = 0, tdi_n = 0, rise_cnt = 0, rise1_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tdo0 = loop0 ? tdi0 : slave_sr[0];

  main_nios2_jtag_scan_master #(.CLK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .tck(tck0), .tms(tms0), .tdi(tdi0), .tdo(tdo0)
  );

  main_nios2_jtag_scan_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_is_ir(c1_is_ir), .cmd_data(c1_data), .rsp_valid(r1_valid),
    .rsp_data(r1_data), .busy(busy1), .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdi1)
  );

  function automatic int b_next(input int s, input logic m);
    case (s)
      B_TLR:   return m ? B_TLR : B_RTI;
      B_RTI:   return m ? B_SDR : B_RTI;
      B_SDR:   return m ? B_SIR : B_CAP;
      B_SIR:   return m ? B_TLR : B_CAP;
      B_CAP:   return m ? B_E1  : B_SH;
      B_SH:    return m ? B_E1  : B_SH;
      B_E1:    return m ? B_UP  : B_SH;
      default: return m ? B_SDR : B_RTI;
    endcase
  endfunction

  // Slave TAP: capture on the rise leaving CAPTURE, shift on rises in SHIFT.
  always @(posedge tck0) begin
    rise_cnt = rise_cnt + 1;
    if (tms_n < 64) tms_bits[tms_n] = tms0;
    tms_n = tms_n + 1;
    if (b_state == B_SH) begin
      if (tdi_n < 64) tdi_bits[tdi_n] = tdi0;
      tdi_n = tdi_n + 1;
      slave_sr = slave_sr >> 1;
    end
    if (b_state == B_CAP) slave_sr = b_ir ? IR_CAP : dr_cap;
    if (b_state == B_SDR) b_ir = tms0;
    b_state = b_next(b_state, tms0);
  end

  always @(posedge tck1) rise1_cnt = rise1_cnt + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd_valid && cmd_ready) begin
        mon_e.data = loop0 ? (cmd_is_ir ? {36'b0, cmd_data[1:0]} : cmd_data)
                           : (cmd_is_ir ? IR_CAP : dr_cap);
        mon_e.cyc  = cyc + 1;
        mon_e.lat  = cmd_is_ir ? 4 * (IW + 6) : 4 * (DW + 5);
        exp_q.push_back(mon_e);
      end
      if (rsp_valid) begin
        mon_e.data = rsp_data; mon_e.cyc = cyc; mon_e.lat = 0;
        got_q.push_back(mon_e);
      end
      if (c1_valid && c1_ready) begin
        mon1_e.data = c1_is_ir ? {36'b0, c1_data[1:0]} : c1_data;
        mon1_e.cyc  = cyc + 1;
        mon1_e.lat  = c1_is_ir ? 2 * (IW + 6) : 2 * (DW + 5);
        exp1_q.push_back(mon1_e);
      end
      if (r1_valid) begin
        mon1_e.data = r1_data; mon1_e.cyc = cyc; mon1_e.lat = 0;
        got1_q.push_back(mon1_e);
      end
    end
  end

  task automatic clear_logs();
    tms_bits = '0; tdi_bits = '0; tms_n = 0; tdi_n = 0; rise_cnt = 0; rise1_cnt = 0;
  endtask

  task automatic send0(input logic is_ir, input logic [DW-1:0] d, output bit ok);
    int k;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_is_ir = is_ir; cmd_data = d;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp0(input int n, input int budget, output bit ok);
    int k;
    ok = 1'b1; k = 0;
    while (got_q.size() < n) begin
      @(negedge clk); k++;
      if (k > budget) begin ok = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    checks++; if (tck0 !== 1'b0) begin errors++; $display("FAIL rst_tck got=%b exp=0", tck0); end
    checks++; if (tms0 !== 1'b1) begin errors++; $display("FAIL rst_tms got=%b exp=1", tms0); end
    checks++; if (tdi0 !== 1'b0) begin errors++; $display("FAIL rst_tdi got=%b exp=0", tdi0); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
    clear_logs();
    @(negedge clk); reset_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cmd_ready && n < 100);
    checks++; if (n !== 24) begin errors++; $display("FAIL rst_seq_len got=%0d exp=24", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after got=%b exp=0", busy); end
    checks++;
    if (tms_n !== 6 || tms_bits[5:0] !== 6'h1F) begin
      errors++; $display("FAIL rst_tms_seq got n=%0d bits=%b exp n=6 bits=011111", tms_n, tms_bits[5:0]);
    end
    $display("reset: ready after %0d cycles, tms periods=%0d", n, tms_n);
  endtask

  task automatic test_ir_scan();
    bit ok; ev_t e, g;
    loop0 = 1'b1; clear_logs();
    send0(1'b1, 38'h2, ok);
    wait_rsp0(1, 200, ok);
    checks++;
    if (!ok || exp_q.size() < 1) begin errors++; $display("FAIL ir_timeout got=%0d rsp exp=1", got_q.size()); return; end
    e = exp_q.pop_front(); g = got_q.pop_front();
    checks++; if (g.data !== e.data) begin errors++; $display("FAIL ir_data got=%h exp=%h", g.data, e.data); end
    checks++; if (g.cyc - e.cyc !== e.lat) begin errors++; $display("FAIL ir_latency got=%0d exp=%0d", g.cyc - e.cyc, e.lat); end
    checks++;
    if (tms_n !== 8 || tms_bits[7:0] !== 8'h63) begin
      errors++; $display("FAIL ir_tms_seq got n=%0d bits=%b exp n=8 bits=01100011", tms_n, tms_bits[7:0]);
    end
    checks++;
    if (tdi_n !== 2 || tdi_bits[1:0] !== 2'b10) begin
      errors++; $display("FAIL ir_tdi got n=%0d bits=%b exp n=2 bits=10", tdi_n, tdi_bits[1:0]);
    end
    $display("ir scan: rsp=%h latency=%0d tck=%0d", g.data, g.cyc - e.cyc, rise_cnt);
  endtask

  task automatic test_dr_scan();
    bit ok; ev_t e, g;
    logic [42:0] exp_tms;
    logic [DW-1:0] d;
    d = 38'h2A_5A5A_5A5A;
    exp_tms = '0; exp_tms[0] = 1'b1; exp_tms[40] = 1'b1; exp_tms[41] = 1'b1;
    loop0 = 1'b0; dr_cap = 38'h15_A5A5_A5A5; clear_logs();
    send0(1'b0, d, ok);
    wait_rsp0(1, 400, ok);
    checks++;
    if (!ok || exp_q.size() < 1) begin errors++; $display("FAIL dr_timeout got=%0d rsp exp=1", got_q.size()); return; end
    e = exp_q.pop_front(); g = got_q.pop_front();
    checks++; if (g.data !== e.data) begin errors++; $display("FAIL dr_data got=%h exp=%h", g.data, e.data); end
    checks++; if (g.cyc - e.cyc !== e.lat) begin errors++; $display("FAIL dr_latency got=%0d exp=%0d", g.cyc - e.cyc, e.lat); end
    checks++;
    if (tms_n !== 43 || tms_bits[42:0] !== exp_tms) begin
      errors++; $display("FAIL dr_tms_seq got n=%0d bits=%h exp n=43 bits=%h", tms_n, tms_bits[42:0], exp_tms);
    end
    checks++;
    if (tdi_n !== DW || tdi_bits[DW-1:0] !== d) begin
      errors++; $display("FAIL dr_tdi got n=%0d bits=%h exp n=38 bits=%h", tdi_n, tdi_bits[DW-1:0], d);
    end
    $display("dr scan: rsp=%h latency=%0d tck=%0d", g.data, g.cyc - e.cyc, rise_cnt);
    loop0 = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok; int k; ev_t e0, e1, g0, g1;
    loop0 = 1'b1; clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_is_ir = 1'b1; cmd_data = 38'h1;
    for (k = 0; k < 100; k++) begin @(negedge clk); if (cmd_ready) break; end
    @(posedge clk); #1;
    cmd_data = 38'h2;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (cmd_ready) break; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = 38'h3;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp0(2, 300, ok);
    repeat (60) @(negedge clk);
    checks++;
    if (!ok || got_q.size() !== 2 || exp_q.size() !== 2) begin
      errors++; $display("FAIL b2b_count got rsp=%0d acc=%0d exp 2/2", got_q.size(), exp_q.size());
      exp_q.delete(); got_q.delete(); return;
    end
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    g0 = got_q.pop_front(); g1 = got_q.pop_front();
    checks++; if (g0.data !== e0.data) begin errors++; $display("FAIL b2b_data0 got=%h exp=%h", g0.data, e0.data); end
    checks++; if (g1.data !== e1.data) begin errors++; $display("FAIL b2b_data1 got=%h exp=%h", g1.data, e1.data); end
    checks++; if (g0.cyc - e0.cyc !== e0.lat) begin errors++; $display("FAIL b2b_lat0 got=%0d exp=%0d", g0.cyc - e0.cyc, e0.lat); end
    checks++; if (g1.cyc - e1.cyc !== e1.lat) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=%0d", g1.cyc - e1.cyc, e1.lat); end
    checks++; if (e1.cyc !== g0.cyc + 1) begin errors++; $display("FAIL b2b_accept_edge got=%0d exp=%0d", e1.cyc, g0.cyc + 1); end
    checks++; if (rise_cnt !== 16) begin errors++; $display("FAIL b2b_tck_rises got=%0d exp=16", rise_cnt); end
    $display("back-to-back: rsp0=%h rsp1=%h second accept edge=%0d tck=%0d", g0.data, g1.data, e1.cyc, rise_cnt);
  endtask

  task automatic test_reset_mid_scan();
    bit ok; int k, n;
    loop0 = 1'b1; clear_logs();
    send0(1'b0, 38'h3F_0F0F_0F0F, ok);
    for (k = 0; k < 400; k++) begin @(negedge clk); if (tdi_n >= 20) break; end
    checks++; if (tdi_n < 20) begin errors++; $display("FAIL mid_reach_bit20 got=%0d exp=20", tdi_n); end
    @(negedge clk); reset_n = 1'b0; #1;
    checks++; if (tck0 !== 1'b0) begin errors++; $display("FAIL mid_tck got=%b exp=0", tck0); end
    checks++; if (tms0 !== 1'b1) begin errors++; $display("FAIL mid_tms got=%b exp=1", tms0); end
    checks++; if (tdi0 !== 1'b0) begin errors++; $display("FAIL mid_tdi got=%b exp=0", tdi0); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b/%b exp=1/0", busy, cmd_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin errors++; $display("FAIL mid_rsp got=%b/%h exp=0/0", rsp_valid, rsp_data); end
    repeat (3) @(negedge clk);
    exp_q.delete();
    clear_logs();
    reset_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cmd_ready && n < 100);
    checks++; if (n !== 24) begin errors++; $display("FAIL mid_reseq_len got=%0d exp=24", n); end
    repeat (20) @(negedge clk);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL mid_no_rsp got=%0d exp=0", got_q.size()); got_q.delete(); end
    $display("reset mid-scan: ready after %0d cycles, stray rsp=%0d", n, got_q.size());
  endtask

  task automatic test_clkdiv1();
    int k; ev_t e, g;
    clear_logs();
    @(posedge clk); #1;
    c1_valid = 1'b1; c1_is_ir = 1'b1; c1_data = 38'h1;
    for (k = 0; k < 100; k++) begin @(negedge clk); if (c1_ready) break; end
    @(posedge clk); #1;
    c1_valid = 1'b0;
    k = 0;
    while (got1_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (got1_q.size() < 1 || exp1_q.size() < 1) begin errors++; $display("FAIL div1_timeout got=%0d rsp exp=1", got1_q.size()); return; end
    e = exp1_q.pop_front(); g = got1_q.pop_front();
    checks++; if (g.data !== e.data) begin errors++; $display("FAIL div1_data got=%h exp=%h", g.data, e.data); end
    checks++; if (g.cyc - e.cyc !== e.lat) begin errors++; $display("FAIL div1_latency got=%0d exp=%0d", g.cyc - e.cyc, e.lat); end
    checks++; if (rise1_cnt !== 8) begin errors++; $display("FAIL div1_tck_rises got=%0d exp=8", rise1_cnt); end
    $display("clk_div=1 ir scan: rsp=%h latency=%0d tck=%0d", g.data, g.cyc - e.cyc, rise1_cnt);
  endtask

  initial begin
    test_reset();
    test_ir_scan();
    test_dr_scan();
    test_back_to_back();
    test_reset_mid_scan();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
